// File: rtl/alarm_set_time_rx.sv
// Alarm receive path: latches user set/unset commands, compares the stored alarm
// time against the running POSIX time on each second tick, and drives the ring
// output with auto-timeout and a bounded number of snoozes.
module alarm_set_time_rx #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned SNOOZE_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] usr_posix_time_i,
    input  logic        usr_posix_time_en_i,
    input  logic        usr_unset_alarm_i,
    input  logic [31:0] cur_posix_time_i,
    input  logic        sec_tick_i,
    input  logic        stop_i,
    input  logic        snooze_i,
    output logic [31:0] alarm_time_o,
    output logic        alarm_armed_o,
    output logic        alarm_ring_o,
    output logic        alarm_fire_o
);

    localparam int unsigned RW = $clog2(RING_SEC + 1);
    localparam int unsigned SW = $clog2(SNOOZE_SEC + 1);
    localparam int unsigned NW = $clog2(SNOOZE_MAX + 1);

    localparam logic [RW-1:0] RingLast = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SnzLast  = SW'(SNOOZE_SEC - 1);
    localparam logic [NW-1:0] SnzMax   = NW'(SNOOZE_MAX);

    typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

    state_e        state_q, state_d;
    logic [31:0]   time_q, time_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic [NW-1:0] snooze_num_q, snooze_num_d;
    logic          armed_q, armed_d;
    logic          ring_q, ring_d;
    logic          fire_q, fire_d;

    // Next-state: unset > set > stop > snooze > tick-driven transitions.
    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        snooze_num_d = snooze_num_q;
        fire_d       = 1'b0;

        if (usr_unset_alarm_i) begin
            state_d      = StIdle;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
            snooze_num_d = '0;
        end else if (usr_posix_time_en_i) begin
            // A tick in the same cycle is deliberately dropped.
            time_d       = usr_posix_time_i;
            state_d      = StArmed;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
            snooze_num_d = '0;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (sec_tick_i && (cur_posix_time_i >= time_q)) begin
                        state_d    = StRinging;
                        ring_cnt_d = '0;
                        fire_d     = 1'b1;
                    end
                end
                StRinging: begin
                    if (stop_i) begin
                        state_d    = StIdle;
                        ring_cnt_d = '0;
                    end else if (snooze_i && (snooze_num_q < SnzMax)) begin
                        state_d      = StSnooze;
                        snooze_num_d = snooze_num_q + NW'(1);
                        snooze_cnt_d = '0;
                    end else if (sec_tick_i) begin
                        // Exhausted snooze requests fall through so ringing still times out.
                        if (ring_cnt_q == RingLast) begin
                            state_d    = StIdle;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RW'(1);
                        end
                    end
                end
                StSnooze: begin
                    if (stop_i) begin
                        state_d      = StIdle;
                        snooze_cnt_d = '0;
                    end else if (sec_tick_i) begin
                        if (snooze_cnt_q == SnzLast) begin
                            state_d      = StRinging;
                            ring_cnt_d   = '0;
                            snooze_cnt_d = '0;
                            fire_d       = 1'b1;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q + SW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        armed_d = (state_d == StArmed) || (state_d == StSnooze);
        ring_d  = (state_d == StRinging);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            time_q       <= '0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            snooze_num_q <= '0;
            armed_q      <= 1'b0;
            ring_q       <= 1'b0;
            fire_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            snooze_num_q <= snooze_num_d;
            armed_q      <= armed_d;
            ring_q       <= ring_d;
            fire_q       <= fire_d;
        end
    end

    assign alarm_time_o  = time_q;
    assign alarm_armed_o = armed_q;
    assign alarm_ring_o  = ring_q;
    assign alarm_fire_o  = fire_q;

endmodule

// File: tb/tb_alarm_set_time_rx.sv
// Bench for alarm_set_time_rx: directed vector table, hand-written corner
// sequences, and a randomized run against a remaining-time reference model.
module tb_alarm_set_time_rx;

    localparam int unsigned RingSec   = 4;
    localparam int unsigned SnoozeSec = 5;
    localparam int unsigned SnoozeMax = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] usr_posix_time_i = '0;
    logic        usr_posix_time_en_i = 1'b0;
    logic        usr_unset_alarm_i = 1'b0;
    logic [31:0] cur_posix_time_i = '0;
    logic        sec_tick_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        snooze_i = 1'b0;
    logic [31:0] alarm_time_o;
    logic        alarm_armed_o;
    logic        alarm_ring_o;
    logic        alarm_fire_o;

    int checks = 0;
    int failures = 0;

    alarm_set_time_rx #(
        .RING_SEC   (RingSec),
        .SNOOZE_SEC (SnoozeSec),
        .SNOOZE_MAX (SnoozeMax)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .usr_posix_time_i    (usr_posix_time_i),
        .usr_posix_time_en_i (usr_posix_time_en_i),
        .usr_unset_alarm_i   (usr_unset_alarm_i),
        .cur_posix_time_i    (cur_posix_time_i),
        .sec_tick_i          (sec_tick_i),
        .stop_i              (stop_i),
        .snooze_i            (snooze_i),
        .alarm_time_o        (alarm_time_o),
        .alarm_armed_o       (alarm_armed_o),
        .alarm_ring_o        (alarm_ring_o),
        .alarm_fire_o        (alarm_fire_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: mode plus "ticks remaining" budgets.
    localparam int MIdle = 0, MArmed = 1, MRing = 2, MSnooze = 3;
    int          m_mode;
    logic [31:0] m_time;
    int          m_ring_left;
    int          m_sil_left;
    int          m_snoozes;
    bit          m_fire;

    task automatic mdl_reset();
        m_mode = MIdle; m_time = '0; m_ring_left = 0; m_sil_left = 0;
        m_snoozes = 0; m_fire = 1'b0;
    endtask

    task automatic mdl_step(input bit se, input logic [31:0] st, input bit un,
                            input logic [31:0] cur, input bit tk, input bit sp,
                            input bit sz);
        m_fire = 1'b0;
        if (un) begin
            m_mode = MIdle;
        end else if (se) begin
            m_time = st; m_mode = MArmed; m_snoozes = 0;
        end else if (m_mode == MArmed) begin
            if (tk && cur >= m_time) begin
                m_mode = MRing; m_ring_left = RingSec; m_fire = 1'b1;
            end
        end else if (m_mode == MRing) begin
            if (sp) m_mode = MIdle;
            else if (sz && m_snoozes < SnoozeMax) begin
                m_mode = MSnooze; m_snoozes++; m_sil_left = SnoozeSec;
            end else if (tk) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = MIdle;
            end
        end else if (m_mode == MSnooze) begin
            if (sp) m_mode = MIdle;
            else if (tk) begin
                m_sil_left--;
                if (m_sil_left == 0) begin
                    m_mode = MRing; m_ring_left = RingSec; m_fire = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input bit ea, input bit er, input bit ef,
                           input logic [31:0] et);
        chk({name, ".armed"}, {31'd0, alarm_armed_o}, {31'd0, ea});
        chk({name, ".ring"},  {31'd0, alarm_ring_o},  {31'd0, er});
        chk({name, ".fire"},  {31'd0, alarm_fire_o},  {31'd0, ef});
        chk({name, ".time"},  alarm_time_o, et);
    endtask

    task automatic chk_model(input string name);
        chk_out(name, (m_mode == MArmed) || (m_mode == MSnooze), m_mode == MRing, m_fire,
                m_time);
    endtask

    // Drive one cycle of inputs, clock it, update the model, leave #1 after edge.
    task automatic cyc(input bit se, input logic [31:0] st, input bit un,
                       input logic [31:0] cur, input bit tk, input bit sp, input bit sz);
        usr_posix_time_en_i = se; usr_posix_time_i = st; usr_unset_alarm_i = un;
        cur_posix_time_i = cur; sec_tick_i = tk; stop_i = sp; snooze_i = sz;
        @(posedge clk_i);
        #1;
        mdl_step(se, st, un, cur, tk, sp, sz);
    endtask

    task automatic tick(input logic [31:0] cur);
        cyc(1'b0, 32'd0, 1'b0, cur, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit se; logic [31:0] st; bit un; logic [31:0] cur; bit tk; bit sp; bit sz;
        bit ea; bit er; bit ef; logic [31:0] et;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // set/unset/cur/tick/stop/snooze -> armed/ring/fire/time
        tbl[0]  = '{1, 1000, 0, 990,  0, 0, 0,  1, 0, 0, 1000};
        tbl[1]  = '{0, 0,    0, 999,  1, 0, 0,  1, 0, 0, 1000};
        tbl[2]  = '{0, 0,    0, 1000, 1, 0, 0,  0, 1, 1, 1000};
        tbl[3]  = '{0, 0,    0, 1000, 0, 0, 0,  0, 1, 0, 1000};
        tbl[4]  = '{0, 0,    0, 1000, 0, 1, 0,  0, 0, 0, 1000};
        tbl[5]  = '{0, 0,    0, 1001, 1, 0, 1,  0, 0, 0, 1000};
        tbl[6]  = '{1, 3000, 0, 1001, 0, 0, 0,  1, 0, 0, 3000};
        tbl[7]  = '{1, 2000, 1, 5000, 1, 0, 0,  0, 0, 0, 3000};
        tbl[8]  = '{0, 0,    0, 5001, 1, 0, 0,  0, 0, 0, 3000};
        tbl[9]  = '{1, 500,  0, 800,  0, 0, 0,  1, 0, 0, 500};
        tbl[10] = '{0, 0,    0, 800,  1, 0, 0,  0, 1, 1, 500};
        tbl[11] = '{1, 900,  0, 901,  1, 0, 0,  1, 0, 0, 900};
        tbl[12] = '{0, 0,    0, 850,  1, 0, 0,  1, 0, 0, 900};
        tbl[13] = '{0, 0,    0, 900,  1, 0, 0,  0, 1, 1, 900};
        tbl[14] = '{0, 0,    0, 900,  0, 0, 1,  1, 0, 0, 900};
        tbl[15] = '{0, 0,    0, 901,  1, 1, 0,  0, 0, 0, 900};
        tbl[16] = '{0, 0,    1, 902,  1, 0, 0,  0, 0, 0, 900};

        mdl_reset();
        #12;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].se, tbl[i].st, tbl[i].un, tbl[i].cur, tbl[i].tk, tbl[i].sp,
                tbl[i].sz);
            chk_out($sformatf("vec%0d", i), tbl[i].ea, tbl[i].er, tbl[i].ef, tbl[i].et);
        end

        // Set 1000 at cur=990, ten ticks up to 1000.
        cyc(1'b1, 32'd1000, 1'b0, 32'd990, 1'b0, 1'b0, 1'b0);
        for (int c = 991; c <= 999; c++) begin
            tick(32'(c));
            chk_out("t1_wait", 1'b1, 1'b0, 1'b0, 32'd1000);
        end
        tick(32'd1000);
        chk_out("t1_fire", 1'b0, 1'b1, 1'b1, 32'd1000);
        cyc(1'b0, 32'd0, 1'b0, 32'd1000, 1'b0, 1'b0, 1'b0);
        chk_out("t1_ring", 1'b0, 1'b1, 1'b0, 32'd1000);

        // Ringing with no input lasts exactly RingSec ticks.
        for (int k = 1; k <= int'(RingSec); k++) begin
            tick(32'(1000 + k));
            chk_out($sformatf("t2_tick%0d", k), 1'b0, k < int'(RingSec), 1'b0, 32'd1000);
            cyc(1'b0, 32'd0, 1'b0, 32'(1000 + k), 1'b0, 1'b0, 1'b0);
        end
        tick(32'd1100);
        chk_out("t2_noreArm", 1'b0, 1'b0, 1'b0, 32'd1000);

        // Two snoozes each silence SnoozeSec ticks; third is ignored.
        cyc(1'b1, 32'd2000, 1'b0, 32'd2000, 1'b0, 1'b0, 1'b0);
        tick(32'd2000);
        chk_out("t3_fire0", 1'b0, 1'b1, 1'b1, 32'd2000);
        for (int s = 0; s < 2; s++) begin
            cyc(1'b0, 32'd0, 1'b0, 32'd2000, 1'b0, 1'b0, 1'b1);
            chk_out($sformatf("t3_snz%0d", s), 1'b1, 1'b0, 1'b0, 32'd2000);
            for (int k = 1; k < int'(SnoozeSec); k++) begin
                tick(32'(2000 + k));
                chk_out($sformatf("t3_quiet%0d_%0d", s, k), 1'b1, 1'b0, 1'b0, 32'd2000);
            end
            tick(32'd2010);
            chk_out($sformatf("t3_refire%0d", s), 1'b0, 1'b1, 1'b1, 32'd2000);
        end
        cyc(1'b0, 32'd0, 1'b0, 32'd2011, 1'b0, 1'b0, 1'b1);
        chk_out("t3_snz_ignored", 1'b0, 1'b1, 1'b0, 32'd2000);

        // Into snooze, then asynchronous reset.
        cyc(1'b0, 32'd0, 1'b0, 32'd2011, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'd3000, 1'b0, 32'd3000, 1'b0, 1'b0, 1'b0);
        tick(32'd3000);
        cyc(1'b0, 32'd0, 1'b0, 32'd3000, 1'b0, 1'b0, 1'b1);
        chk_out("t6_pre", 1'b1, 1'b0, 1'b0, 32'd3000);
        cyc(1'b0, 32'd0, 1'b0, 32'd3001, 1'b1, 1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        mdl_reset();
        chk_out("t6_async", 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(32'(4000 + k));
            chk_out("t6_idle", 1'b0, 1'b0, 1'b0, 32'd0);
        end

        // Randomized run against the model.
        begin
            logic [31:0] cur = 32'd10000;
            for (int n = 0; n < 4000; n++) begin
                bit se = ($urandom_range(0, 24) == 0);
                bit un = ($urandom_range(0, 59) == 0);
                bit tk = ($urandom_range(0, 2) == 0);
                bit sp = ($urandom_range(0, 39) == 0);
                bit sz = ($urandom_range(0, 5) == 0);
                logic [31:0] st = cur + 32'($urandom_range(0, 12)) - 32'd3;
                if (tk) cur = cur + 32'd1;
                cyc(se, st, un, cur, tk, sp, sz);
                chk_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
